// File: rtl/cram_param_fetch_pkg.sv
// rtl/cram_param_fetch_pkg.sv - shared constants and state type for the constant-memory parameter fetch
package cram_pkg;

  localparam int DATA_W = 20;
  localparam int ADDR_W = 3;

  // Constant-memory addresses of the image-geometry words
  localparam int CM_SRC_BASE  = 3;
  localparam int CM_DST_BASE  = 4;
  localparam int CM_SRC_LAST  = 5;
  localparam int CM_SRC_WIDTH = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/cram_param_fetch_if.sv
// rtl/cram_param_fetch_if.sv - request, constant-memory read and parameter result signals of the fetch unit
interface cram_param_fetch_if #(
  parameter int DATA_W = cram_pkg::DATA_W,
  parameter int ADDR_W = cram_pkg::ADDR_W
);

  logic              start;
  logic              cm_r;
  logic [ADDR_W-1:0] cm_addr;
  logic [DATA_W-1:0] cm_out;
  logic [DATA_W-1:0] src_base;
  logic [DATA_W-1:0] dst_base;
  logic [DATA_W-1:0] src_last;
  logic [DATA_W-1:0] src_width;
  logic              busy;
  logic              done;
  logic              valid;
  logic              cfg_err;

  // Fetch unit side
  modport master (
    input  start, cm_out,
    output cm_r, cm_addr, src_base, dst_base, src_last, src_width,
           busy, done, valid, cfg_err
  );

  // Requester / memory side
  modport slave (
    output start, cm_out,
    input  cm_r, cm_addr, src_base, dst_base, src_last, src_width,
           busy, done, valid, cfg_err
  );

endinterface

// File: rtl/cram_param_fetch.sv
// rtl/cram_param_fetch.sv - reads four geometry words from constant memory and presents them with done/valid/cfg_err
module cram_param_fetch #(
  parameter int DATA_W    = cram_pkg::DATA_W,
  parameter int ADDR_W    = cram_pkg::ADDR_W,
  parameter int BASE_ADDR = cram_pkg::CM_SRC_BASE
) (
  input  logic             clock,
  input  logic             rst_n,
  cram_param_fetch_if.master bus
);

  import cram_pkg::*;

  // The last word read sits at BASE_ADDR+3 and must be addressable
  if (BASE_ADDR + 3 >= (1 << ADDR_W)) begin : g_addr_range_bad
    $error("cram_param_fetch: BASE_ADDR+3 does not fit in ADDR_W");
  end

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic              r_cm_r;
  logic [ADDR_W-1:0] r_cm_addr;
  logic [DATA_W-1:0] r_src_base;
  logic [DATA_W-1:0] r_dst_base;
  logic [DATA_W-1:0] r_src_last;
  logic [DATA_W-1:0] r_src_width;
  logic              r_busy;
  logic              r_done;
  logic              r_valid;
  logic              r_cfg_err;

  // Issue reads at cnt 0..3 and capture data two edges behind (cnt 1..4)
  // because the memory registers its read data.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 3'd0;
      r_cm_r      <= 1'b0;
      r_cm_addr   <= '0;
      r_src_base  <= '0;
      r_dst_base  <= '0;
      r_src_last  <= '0;
      r_src_width <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_valid     <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.start) begin
          r_state   <= RUN;
          r_cm_r    <= 1'b1;
          r_cm_addr <= ADDR_W'(BASE_ADDR);
          r_cnt     <= 3'd0;
          r_busy    <= 1'b1;
          r_valid   <= 1'b0;
          r_cfg_err <= 1'b0;
        end
      end else begin
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt < 3'd3) begin
          r_cm_addr <= ADDR_W'(BASE_ADDR + int'(r_cnt) + 1);
        end else begin
          r_cm_r <= 1'b0;
        end
        case (r_cnt)
          3'd1: r_src_base <= bus.cm_out;
          3'd2: r_dst_base <= bus.cm_out;
          3'd3: r_src_last <= bus.cm_out;
          3'd4: begin
            r_src_width <= bus.cm_out;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_valid     <= 1'b1;
            r_cfg_err   <= (bus.cm_out == '0) || (r_src_last < r_src_base);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.cm_r      = r_cm_r;
  assign bus.cm_addr   = r_cm_addr;
  assign bus.src_base  = r_src_base;
  assign bus.dst_base  = r_dst_base;
  assign bus.src_last  = r_src_last;
  assign bus.src_width = r_src_width;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.valid     = r_valid;
  assign bus.cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_cram_param_fetch.sv
// tb/tb_cram_param_fetch.sv - directed self-checking bench for cram_param_fetch
module tb_cram_param_fetch;

  logic clock;
  logic rst_n;

  int vec;
  int errs;

  logic [19:0] mem [0:7];

  cram_param_fetch_if #(.DATA_W(20), .ADDR_W(3)) bus ();

  cram_param_fetch #(.DATA_W(20), .ADDR_W(3), .BASE_ADDR(3)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Constant memory: one-cycle registered read
  always @(posedge clock) begin
    if (bus.cm_r) bus.cm_out <= mem[bus.cm_addr];
  end

  task automatic load_mem(input logic [19:0] w3, input logic [19:0] w4,
                          input logic [19:0] w5, input logic [19:0] w6);
    for (int i = 0; i < 8; i++) mem[i] = 20'hABCDE;
    mem[3] = w3;
    mem[4] = w4;
    mem[5] = w5;
    mem[6] = w6;
  endtask

  task automatic fetch_and_check(input logic [19:0] e_sb, input logic [19:0] e_db,
                                 input logic [19:0] e_sl, input logic [19:0] e_sw,
                                 input logic e_err, input string tag);
    @(negedge clock);
    bus.start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (k == 0) begin
        bus.start = 1'b0;
        vec++;
        if (bus.valid !== 1'b0 || bus.cfg_err !== 1'b0 || bus.busy !== 1'b1) begin
          errs++;
          $display("FAIL %s accept: valid=%b cfg_err=%b busy=%b expected 0 0 1", tag, bus.valid, bus.cfg_err, bus.busy);
        end
      end
      vec++;
      if (bus.cm_r !== 1'b1 || bus.cm_addr !== 3'(3 + k)) begin
        errs++;
        $display("FAIL %s issue%0d: cm_r=%b cm_addr=%0d expected 1 %0d", tag, k, bus.cm_r, bus.cm_addr, 3 + k);
      end
    end
    @(negedge clock);
    vec++;
    if (bus.cm_r !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL %s after_e4: cm_r=%b done=%b busy=%b expected 0 0 1", tag, bus.cm_r, bus.done, bus.busy);
    end
    @(negedge clock);
    vec++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.valid !== 1'b1 || bus.cfg_err !== e_err) begin
      errs++;
      $display("FAIL %s done_flags: done=%b busy=%b valid=%b cfg_err=%b expected 1 0 1 %b", tag, bus.done, bus.busy, bus.valid, bus.cfg_err, e_err);
    end
    vec++;
    if (bus.src_base !== e_sb || bus.dst_base !== e_db || bus.src_last !== e_sl || bus.src_width !== e_sw) begin
      errs++;
      $display("FAIL %s params: got %0d %0d %0d %0d expected %0d %0d %0d %0d", tag,
               bus.src_base, bus.dst_base, bus.src_last, bus.src_width, e_sb, e_db, e_sl, e_sw);
    end
    @(negedge clock);
    vec++;
    if (bus.done !== 1'b0 || bus.valid !== 1'b1 || bus.cfg_err !== e_err) begin
      errs++;
      $display("FAIL %s after_done: done=%b valid=%b cfg_err=%b expected 0 1 %b", tag, bus.done, bus.valid, bus.cfg_err, e_err);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    repeat (10) @(negedge clock);
    vec++;
    if (bus.cm_r !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.valid !== 1'b0 || bus.cfg_err !== 1'b0) begin
      errs++;
      $display("FAIL reset_flags: cm_r=%b busy=%b done=%b valid=%b cfg_err=%b expected all 0",
               bus.cm_r, bus.busy, bus.done, bus.valid, bus.cfg_err);
    end
    vec++;
    if (bus.src_base !== 20'd0 || bus.dst_base !== 20'd0 || bus.src_last !== 20'd0 ||
        bus.src_width !== 20'd0 || bus.cm_addr !== 3'd0) begin
      errs++;
      $display("FAIL reset_params: got %0d %0d %0d %0d addr=%0d expected all 0",
               bus.src_base, bus.dst_base, bus.src_last, bus.src_width, bus.cm_addr);
    end
  endtask

  task automatic test_nominal;
    load_mem(20'd0, 20'd10000, 20'd8259, 20'd118);
    fetch_and_check(20'd0, 20'd10000, 20'd8259, 20'd118, 1'b0, "nominal");
  endtask

  task automatic test_start_ignored;
    int dones;
    dones = 0;
    load_mem(20'd0, 20'd10000, 20'd8259, 20'd118);
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clock);
    end
    vec++;
    if (dones != 1) begin
      errs++;
      $display("FAIL ignored_done_count: got %0d expected 1", dones);
    end
    vec++;
    if (bus.src_base !== 20'd0 || bus.dst_base !== 20'd10000 || bus.src_last !== 20'd8259 ||
        bus.src_width !== 20'd118 || bus.valid !== 1'b1 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL ignored_params: got %0d %0d %0d %0d valid=%b busy=%b expected 0 10000 8259 118 1 0",
               bus.src_base, bus.dst_base, bus.src_last, bus.src_width, bus.valid, bus.busy);
    end
  endtask

  task automatic test_reset_abort;
    int dones;
    dones = 0;
    load_mem(20'd0, 20'd10000, 20'd8259, 20'd118);
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    @(posedge clock);
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if (bus.cm_r !== 1'b0 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      errs++;
      $display("FAIL abort_async: cm_r=%b busy=%b valid=%b expected 0 0 0", bus.cm_r, bus.busy, bus.valid);
    end
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (bus.done === 1'b1) dones++;
    end
    vec++;
    if (dones != 0 || bus.valid !== 1'b0) begin
      errs++;
      $display("FAIL abort_no_done: dones=%0d valid=%b expected 0 0", dones, bus.valid);
    end
    fetch_and_check(20'd0, 20'd10000, 20'd8259, 20'd118, 1'b0, "after_abort");
  endtask

  task automatic test_cfg_err;
    load_mem(20'd0, 20'd10000, 20'd8259, 20'd0);
    fetch_and_check(20'd0, 20'd10000, 20'd8259, 20'd0, 1'b1, "width_zero");
    load_mem(20'd10, 20'd10000, 20'd0, 20'd118);
    fetch_and_check(20'd10, 20'd10000, 20'd0, 20'd118, 1'b1, "last_below_base");
    load_mem(20'd10, 20'd500, 20'd10, 20'd1);
    fetch_and_check(20'd10, 20'd500, 20'd10, 20'd1, 1'b0, "last_equals_base");
    load_mem(20'hFFFFE, 20'd7, 20'hFFFFF, 20'hFFFFF);
    fetch_and_check(20'hFFFFE, 20'd7, 20'hFFFFF, 20'hFFFFF, 1'b0, "full_width");
  endtask

  task automatic test_back_to_back;
    int first_done;
    int second_done;
    first_done  = -1;
    second_done = -1;
    load_mem(20'd1, 20'd2, 20'd3, 20'd4);
    @(negedge clock);
    bus.start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (first_done >= 0 && c == first_done + 1) begin
        vec++;
        if (bus.valid !== 1'b0 || bus.busy !== 1'b1 || bus.cm_r !== 1'b1 || bus.cm_addr !== 3'd3) begin
          errs++;
          $display("FAIL b2b_reaccept: valid=%b busy=%b cm_r=%b cm_addr=%0d expected 0 1 1 3",
                   bus.valid, bus.busy, bus.cm_r, bus.cm_addr);
        end
      end
      if (bus.done === 1'b1) begin
        if (first_done < 0) first_done = c;
        else if (second_done < 0) begin
          second_done = c;
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    vec++;
    if (first_done != 6) begin
      errs++;
      $display("FAIL b2b_first_done: got cycle %0d expected 6", first_done);
    end
    vec++;
    if (second_done - first_done != 6 || second_done < 0) begin
      errs++;
      $display("FAIL b2b_spacing: got %0d expected 6", second_done - first_done);
    end
    repeat (8) @(negedge clock);
    vec++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b1 || bus.src_width !== 20'd4) begin
      errs++;
      $display("FAIL b2b_final: busy=%b valid=%b src_width=%0d expected 0 1 4", bus.busy, bus.valid, bus.src_width);
    end
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 20'd0;
    test_reset();
    test_nominal();
    test_start_ignored();
    test_reset_abort();
    test_cfg_err();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
